// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer placed directly upstream of a register file.
// For each address in [cfg_addr_lo, cfg_addr_hi] it writes a golden pattern,
// arms a fault on that register, reads it back and compares against the pattern.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           begin a campaign (sampled only when idle)
//   cfg_addr_lo/hi                  inclusive address range to test
//   cfg_pattern                     golden write data
//   cfg_fault_mask/type             forwarded to the regfile fault inputs
//   rf_we/rf_waddr/rf_wdata         regfile write port
//   rf_raddr/rf_rdata               regfile read port 1
//   fault_enable/addr/mask/type     regfile fault-injection inputs
//   busy, done                      status (done is a one-cycle pulse)
//   err_cfg                         last accepted start had an illegal range
//   tested_cnt, mismatch_cnt        result counters (mismatch_cnt saturates)
//   last_bad_addr, last_bad_data    most recent failing address and readback
module fault_campaign_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter bit          SKIP_R0  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr_lo,
  input  logic [ADDR_W-1:0] cfg_addr_hi,
  input  logic [WIDTH-1:0]  cfg_pattern,
  input  logic [WIDTH-1:0]  cfg_fault_mask,
  input  logic [1:0]        cfg_fault_type,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [WIDTH-1:0]  rf_rdata,
  output logic              fault_enable,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [WIDTH-1:0]  fault_mask,
  output logic [1:0]        fault_type,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic [CNT_W-1:0]  tested_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] last_bad_addr,
  output logic [WIDTH-1:0]  last_bad_data
);

  typedef enum logic [2:0] {StIdle, StWrite, StInject, StNext, StDone} state_e;

  localparam logic [2:0] LatLast = 3'(READ_LAT);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] hi_q;
  logic [WIDTH-1:0]  pat_q;
  logic [WIDTH-1:0]  mask_q;
  logic [1:0]        type_q;
  logic [2:0]        lat_q;

  logic [ADDR_W-1:0] start_addr;
  logic              range_bad;

  // Address 0 is a hardwired-zero register, so optionally begin at 1.
  always_comb begin
    start_addr = cfg_addr_lo;
    if (SKIP_R0 && (cfg_addr_lo == '0)) start_addr = ADDR_W'(1);
    range_bad = (cfg_addr_lo > cfg_addr_hi) || (32'(cfg_addr_hi) >= DEPTH);
  end

  // All outputs are registered; each is set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      hi_q          <= '0;
      pat_q         <= '0;
      mask_q        <= '0;
      type_q        <= '0;
      lat_q         <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      rf_raddr      <= '0;
      fault_enable  <= 1'b0;
      fault_addr    <= '0;
      fault_mask    <= '0;
      fault_type    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cfg       <= 1'b0;
      tested_cnt    <= '0;
      mismatch_cnt  <= '0;
      last_bad_addr <= '0;
      last_bad_data <= '0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q        <= start_addr;
            hi_q          <= cfg_addr_hi;
            pat_q         <= cfg_pattern;
            mask_q        <= cfg_fault_mask;
            type_q        <= cfg_fault_type;
            err_cfg       <= range_bad;
            tested_cnt    <= '0;
            mismatch_cnt  <= '0;
            last_bad_addr <= '0;
            last_bad_data <= '0;
            // An empty range (only R0 requested) finishes cleanly without error.
            if (range_bad || (start_addr > cfg_addr_hi)) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q  <= StWrite;
              busy     <= 1'b1;
              rf_we    <= 1'b1;
              rf_waddr <= start_addr;
              rf_wdata <= cfg_pattern;
            end
          end
        end
        StWrite: begin
          state_q      <= StInject;
          lat_q        <= '0;
          fault_enable <= 1'b1;
          fault_addr   <= addr_q;
          fault_mask   <= mask_q;
          fault_type   <= type_q;
          rf_raddr     <= addr_q;
        end
        StInject: begin
          if (lat_q == LatLast) begin
            state_q      <= StNext;
            fault_enable <= 1'b0;
            tested_cnt   <= tested_cnt + CNT_W'(1);
            if (rf_rdata != pat_q) begin
              if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
              last_bad_addr <= addr_q;
              last_bad_data <= rf_rdata;
            end
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        StNext: begin
          // Compare before incrementing so a range ending at DEPTH-1 never wraps.
          if (addr_q == hi_q) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            addr_q   <= addr_q + ADDR_W'(1);
            state_q  <= StWrite;
            rf_we    <= 1'b1;
            rf_waddr <= addr_q + ADDR_W'(1);
            rf_wdata <= pat_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Self-checking bench: a behavioural regfile with read-path fault injection,
// directed campaigns from the test plan, a reset-during-run case and random campaigns.
module tb_fault_campaign_ctrl;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_addr_lo, cfg_addr_hi;
  logic [W-1:0]  cfg_pattern, cfg_fault_mask;
  logic [1:0]    cfg_fault_type;
  logic          rf_we;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [W-1:0]  rf_wdata, rf_rdata;
  logic          fault_enable;
  logic [AW-1:0] fault_addr;
  logic [W-1:0]  fault_mask;
  logic [1:0]    fault_type;
  logic          busy, done, err_cfg;
  logic [CW-1:0] tested_cnt, mismatch_cnt;
  logic [AW-1:0] last_bad_addr;
  logic [W-1:0]  last_bad_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fault_campaign_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_addr_lo   (cfg_addr_lo),
    .cfg_addr_hi   (cfg_addr_hi),
    .cfg_pattern   (cfg_pattern),
    .cfg_fault_mask(cfg_fault_mask),
    .cfg_fault_type(cfg_fault_type),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .fault_enable  (fault_enable),
    .fault_addr    (fault_addr),
    .fault_mask    (fault_mask),
    .fault_type    (fault_type),
    .busy          (busy),
    .done          (done),
    .err_cfg       (err_cfg),
    .tested_cnt    (tested_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .last_bad_addr (last_bad_addr),
    .last_bad_data (last_bad_data)
  );

  // Fault coding of the bench regfile: 0 flip, 1 stuck-at-0, 2 stuck-at-1, 3 none.
  function automatic logic [W-1:0] apply_fault(logic [W-1:0] d, logic [W-1:0] m, logic [1:0] t);
    case (t)
      2'd0:    return d ^ m;
      2'd1:    return d & ~m;
      2'd2:    return d | m;
      default: return d;
    endcase
  endfunction

  // Behavioural regfile: R0 reads zero, one-cycle registered read, fault on the read path.
  logic [W-1:0] mem [32];
  logic [W-1:0] rdata_q;
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge clk) begin
    logic [W-1:0] raw;
    if (rf_we && rf_waddr != '0) mem[rf_waddr] <= rf_wdata;
    raw = (rf_raddr == '0) ? '0 : mem[rf_raddr];
    rdata_q <= (fault_enable && fault_addr == rf_raddr) ?
               apply_fault(raw, fault_mask, fault_type) : raw;
  end
  assign rf_rdata = rdata_q;

  // Interface monitors, sampled mid-cycle.
  logic [AW-1:0] wq[$];
  int fe_cycles = 0;
  int overlap   = 0;
  always @(negedge clk) begin
    if (rf_we) wq.push_back(rf_waddr);
    if (fault_enable) fe_cycles++;
    if (rf_we && fault_enable && rf_waddr == fault_addr) overlap++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // glitch > 0 pulses start with scrambled config on that cycle of the run.
  task automatic run_campaign(input string name, input int lo, input int hi,
                              input logic [W-1:0] pat, input logic [W-1:0] mask,
                              input logic [1:0] typ, input int glitch);
    int first, n, mm, lat, bad_a;
    bit err, got;
    logic [W-1:0] rd, bad_d;
    // Reference: the address list and expected readbacks straight from the campaign rules.
    err   = (lo > hi) || (hi >= 32);
    first = (lo == 0) ? 1 : lo;
    n     = (err || first > hi) ? 0 : hi - first + 1;
    mm = 0; bad_a = 0; bad_d = '0;
    for (int a = first; a < first + n; a++) begin
      rd = apply_fault(pat, mask, typ);
      if (rd != pat) begin mm++; bad_a = a; bad_d = rd; end
    end

    @(negedge clk);
    cfg_addr_lo = AW'(lo); cfg_addr_hi = AW'(hi);
    cfg_pattern = pat; cfg_fault_mask = mask; cfg_fault_type = typ;
    start = 1'b1;
    wq.delete();
    fe_cycles = 0;
    lat = 0; got = 0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      start = (lat == glitch);
      // Config changes after the accepted start must not matter.
      cfg_addr_lo = AW'($urandom); cfg_addr_hi = AW'($urandom);
      cfg_pattern = $urandom; cfg_fault_mask = $urandom; cfg_fault_type = 2'($urandom);
    end
    start = 1'b0;
    check_eq({name, " done_seen"}, 64'(got), 64'd1);
    check_eq({name, " done_latency"}, 64'(lat), 64'(1 + n * (3 + RL)));
    check_eq({name, " tested_cnt"}, 64'(tested_cnt), 64'(n));
    check_eq({name, " mismatch_cnt"}, 64'(mismatch_cnt), 64'(mm));
    check_eq({name, " err_cfg"}, 64'(err_cfg), 64'(err));
    check_eq({name, " busy_at_done"}, 64'(busy), 64'd0);
    check_eq({name, " write_count"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < wq.size() && i < n; i++)
      check_eq({name, " write_addr"}, 64'(wq[i]), 64'(first + i));
    check_eq({name, " fault_cycles"}, 64'(fe_cycles), 64'(n * (1 + RL)));
    if (mm > 0) begin
      check_eq({name, " last_bad_addr"}, 64'(last_bad_addr), 64'(bad_a));
      check_eq({name, " last_bad_data"}, 64'(last_bad_data), 64'(bad_d));
    end
    @(negedge clk);
    check_eq({name, " done_pulse_width"}, 64'(done), 64'd0);
    check_eq({name, " hold_tested"}, 64'(tested_cnt), 64'(n));
  endtask

  task automatic reset_mid_run();
    bit seen = 0;
    @(negedge clk);
    cfg_addr_lo = 5'd1; cfg_addr_hi = 5'd8; cfg_pattern = 32'h1234_5678;
    cfg_fault_mask = 32'h0000_00ff; cfg_fault_type = 2'd0;
    start = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (fault_enable && fault_addr == 5'd3) seen = 1;
    end
    check_eq("rst_reached_inject_addr3", 64'(seen), 64'd1);
    check_eq("rst_tested_before", 64'(tested_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_fault_enable", 64'(fault_enable), 64'd0);
    check_eq("rst_async_busy", 64'(busy), 64'd0);
    check_eq("rst_async_tested", 64'(tested_cnt), 64'd0);
    check_eq("rst_async_mismatch", 64'(mismatch_cnt), 64'd0);
    check_eq("rst_async_fault_addr", 64'(fault_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0;
    cfg_addr_lo = '0; cfg_addr_hi = '0; cfg_pattern = '0;
    cfg_fault_mask = '0; cfg_fault_type = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_rf_we", 64'(rf_we), 64'd0);
    check_eq("reset_fault_enable", 64'(fault_enable), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_err_cfg", 64'(err_cfg), 64'd0);
    check_eq("reset_counts", 64'({tested_cnt, mismatch_cnt}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_campaign("clean", 1, 4, 32'hA5A5_A5A5, 32'h0, 2'd0, 0);
    run_campaign("bitflip", 1, 4, 32'hA5A5_A5A5, 32'h1, 2'd0, 0);
    run_campaign("r0_skip", 0, 0, 32'hDEAD_BEEF, 32'hF, 2'd0, 0);
    run_campaign("bad_range", 5, 2, 32'h5555_AAAA, 32'hF, 2'd1, 0);
    run_campaign("after_bad", 2, 3, 32'h5555_AAAA, 32'h0, 2'd3, 0);
    run_campaign("top_range", 30, 31, 32'h0F0F_F0F0, 32'hF000_0000, 2'd2, 0);
    run_campaign("stuck0", 7, 9, 32'hFFFF_FFFF, 32'h8000_0001, 2'd1, 0);
    run_campaign("ignored_start", 1, 6, 32'hCAFE_F00D, 32'h0, 2'd0, 7);
    reset_mid_run();

    for (int k = 0; k < 25; k++) begin
      int lo, hi, g;
      lo = $urandom_range(0, 31);
      hi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                       : $urandom_range(lo, (lo + 6 > 31) ? 31 : lo + 6);
      g = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 5) : 0;
      run_campaign("random", lo, hi, $urandom,
                   ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom, 2'($urandom), g);
    end

    check_eq("no_fault_during_write", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fault_campaign_ctrl.md
Name: fault_campaign_ctrl

Overview:
- Sequencer that sits directly upstream of regfile. It drives regfile's write port, read port 1 and fault-injection inputs, and consumes rdata1.
- For every register in a configured address range it writes a golden pattern, arms a fault on that register, reads it back and compares against the pattern.
- It reports the mismatch count, the last failing address and the last failing data. These results go to board-level LEDs/switches or a test bench.

Parameters:
- WIDTH, 32, data width; must match regfile.
- DEPTH, 32, number of registers.
- ADDR_W, 5, address width, >= clog2(DEPTH).
- READ_LAT, 1, cycles from rf_raddr valid to rf_rdata valid; legal range 0..7.
- CNT_W, 16, width of the result counters.
- SKIP_R0, 1, when 1 address 0 is never tested (hardwired-zero register).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a campaign; sampled only in IDLE
- cfg_addr_lo  in  ADDR_W  first address
- cfg_addr_hi  in  ADDR_W  last address (inclusive)
- cfg_pattern  in  WIDTH  golden write data
- cfg_fault_mask  in  WIDTH  passed to regfile fault_mask
- cfg_fault_type  in  2  passed to regfile fault_type; coding defined by regfile
- rf_we  out  1  regfile write enable
- rf_waddr  out  ADDR_W  regfile write address
- rf_wdata  out  WIDTH  regfile write data
- rf_raddr  out  ADDR_W  regfile raddr1
- rf_rdata  in  WIDTH  regfile rdata1
- fault_enable  out  1  to regfile
- fault_addr  out  ADDR_W  to regfile
- fault_mask  out  WIDTH  to regfile
- fault_type  out  2  to regfile
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse at campaign end
- err_cfg  out  1  last start had an illegal range; sticky until next accepted start
- tested_cnt  out  CNT_W  addresses tested
- mismatch_cnt  out  CNT_W  readbacks != cfg_pattern; saturates at all-ones
- last_bad_addr  out  ADDR_W  address of the most recent mismatch
- last_bad_data  out  WIDTH  rf_rdata at the most recent mismatch

Behaviour:
- Reset (asynchronous, rst_n=0): every output is 0 and the state is IDLE. This includes fault_enable=0 and rf_we=0 immediately, with no clock edge required.
- Configuration inputs are latched on the accepted start; later changes to them have no effect on a running campaign.
- States: IDLE, WRITE, INJECT, NEXT, DONE.
- IDLE: busy=0.
  - start=1: latch config, clear err_cfg and all counters, set addr=cfg_addr_lo, or addr=1 if SKIP_R0 and lo==0.
  - If lo>hi, hi>=DEPTH, or the adjusted addr>hi: set err_cfg only for the illegal-range cases, then go to DONE with no regfile writes.
  - Otherwise go to WRITE.
- WRITE (1 cycle): rf_we=1, rf_waddr=addr, rf_wdata=pattern, fault_enable=0.
- INJECT (1+READ_LAT cycles):
  - Drive fault_enable=1, fault_addr=addr, fault_mask, fault_type, rf_raddr=addr.
  - In the final INJECT cycle, sample rf_rdata, increment tested_cnt, and on rf_rdata!=pattern increment mismatch_cnt and update last_bad_addr/last_bad_data.
- NEXT (1 cycle): fault_enable=0. If addr==hi go to DONE, else addr+1 and go to WRITE.
  - The comparison is made before the increment, so hi=DEPTH-1 never wraps to 0.
- Per-address cost is 3+READ_LAT cycles (4 at default).
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- busy is 1 in WRITE, INJECT and NEXT.
- start while busy or in DONE is ignored.
- Result outputs hold from DONE until the next accepted start.
- rf_raddr and fault_addr hold their last value when idle. rf_we and fault_enable are 0 outside WRITE and INJECT respectively.
- fault_enable is never asserted during a regfile write to the same address.

Test Plan:
- Clean run: lo=1, hi=4, pattern=0xA5A5A5A5, mask=0, READ_LAT=1, real regfile -> 4 writes; done pulses 17 cycles after the start edge; tested_cnt=4; mismatch_cnt=0; err_cfg=0.
- Bit-flip run: as above with mask=0x00000001 and the regfile bit-flip fault_type code -> mismatch_cnt=4; last_bad_addr=4; last_bad_data=0xA5A5A5A4.
- R0 skip: lo=0, hi=0, SKIP_R0=1 -> done one cycle after start; tested_cnt=0; rf_we never asserted; err_cfg=0.
- Bad range: lo=5, hi=2 -> err_cfg=1; done pulse; no rf_we; fault_enable stays 0. A following legal start clears err_cfg.
- Top of range: lo=30, hi=31 -> exactly addresses 30 and 31 written and tested, no access to address 0; tested_cnt=2.
- Reset mid-campaign: drop rst_n while in INJECT on addr 3 -> fault_enable, busy and counters go to 0 before the next clk edge. A start pulse mid-run, with rst_n held high, is ignored and tested_cnt is unaffected.
